// File: rtl/noc_router.sv
// One node of a 4-node bidirectional ring: three FWFT input FIFOs, XY-free ring routing, per-output round-robin.
// Latency: one registered hop (write at edge k, flit on dataOut* after edge k+1).
// Backpressure: an output is not granted while its downstream read_Full*/read_almostFull* is high.
module noc_router_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             almost_full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o        = (cnt_q == FULL_CNT);
    assign almost_full_o = (cnt_q >= AFULL_CNT);
    assign empty_o       = (cnt_q == '0);
    assign push_ok       = push_vld_i && !full_o;
    assign pop_ok        = pop_i && !empty_o;
    assign head_dat_o    = mem_q[rd_ptr_q];

    // Pointers wrap naturally at DEPTH; full/empty come from the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        cnt_d    = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module noc_router #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int ID    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             writeE,
    input  logic             writeW,
    input  logic             writeL,
    input  logic             read_FullE,
    input  logic             read_FullW,
    input  logic             read_FullL,
    input  logic             read_almostFullE,
    input  logic             read_almostFullW,
    input  logic             read_almostFullL,
    input  logic [WIDTH-1:0] dataInE,
    input  logic [WIDTH-1:0] dataInW,
    input  logic [WIDTH-1:0] dataInL,
    output logic [WIDTH-1:0] dataOutE,
    output logic [WIDTH-1:0] dataOutW,
    output logic [WIDTH-1:0] dataOutL,
    output logic             writeOutE,
    output logic             writeOutW,
    output logic             writeOutL,
    output logic             fullE,
    output logic             fullW,
    output logic             fullL,
    output logic             almost_fullE,
    output logic             almost_fullW,
    output logic             almost_fullL
);
    localparam logic [1:0] MY_ID  = 2'(ID);
    localparam logic [1:0] PORT_E = 2'd0;
    localparam logic [1:0] PORT_W = 2'd1;
    localparam logic [1:0] PORT_L = 2'd2;

    logic [2:0]       push_vld, pop, empty, full, afull, elig;
    logic [WIDTH-1:0] push_dat [3];
    logic [WIDTH-1:0] head_dat [3];
    logic [1:0]       dst_port [3];
    logic [2:0]       req      [3];
    logic [2:0]       gnt      [3];
    logic [1:0]       rr_q     [3];
    logic [1:0]       rr_d     [3];
    logic [WIDTH-1:0] out_dat_q [3];
    logic [WIDTH-1:0] out_dat_d [3];
    logic [2:0]       out_vld_q, out_vld_d;

    function automatic logic [1:0] route_port(input logic [1:0] dest);
        logic [1:0] d;
        d = dest - MY_ID;
        case (d)
            2'd0:    route_port = PORT_L;
            2'd3:    route_port = PORT_W;
            default: route_port = PORT_E;
        endcase
    endfunction

    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
        logic [2:0] g;
        g = '0;
        case (ptr)
            PORT_W: begin
                if (r[1]) g = 3'b010; else if (r[2]) g = 3'b100; else if (r[0]) g = 3'b001;
            end
            PORT_L: begin
                if (r[2]) g = 3'b100; else if (r[0]) g = 3'b001; else if (r[1]) g = 3'b010;
            end
            default: begin
                if (r[0]) g = 3'b001; else if (r[1]) g = 3'b010; else if (r[2]) g = 3'b100;
            end
        endcase
        rr_pick = g;
    endfunction

    assign push_vld    = {writeL, writeW, writeE};
    assign push_dat[0] = dataInE;
    assign push_dat[1] = dataInW;
    assign push_dat[2] = dataInL;
    assign elig        = ~({read_FullL, read_FullW, read_FullE} |
                           {read_almostFullL, read_almostFullW, read_almostFullE});

    for (genvar i = 0; i < 3; i++) begin : g_in
        noc_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk           (clk),
            .reset         (reset),
            .push_vld_i    (push_vld[i]),
            .push_dat_i    (push_dat[i]),
            .pop_i         (pop[i]),
            .head_dat_o    (head_dat[i]),
            .empty_o       (empty[i]),
            .full_o        (full[i]),
            .almost_full_o (afull[i])
        );
        assign dst_port[i] = route_port(head_dat[i][WIDTH-1 -: 2]);
    end

    // Each input requests exactly one output, so grants never pop a FIFO twice.
    always_comb begin
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 3; i++) begin
                req[o][i] = !empty[i] && (dst_port[i] == 2'(o));
            end
            gnt[o]       = elig[o] ? rr_pick(req[o], rr_q[o]) : 3'b000;
            rr_d[o]      = gnt[o][0] ? PORT_W : gnt[o][1] ? PORT_L : gnt[o][2] ? PORT_E : rr_q[o];
            out_vld_d[o] = |gnt[o];
            out_dat_d[o] = out_dat_q[o];
            for (int i = 0; i < 3; i++) begin
                if (gnt[o][i]) out_dat_d[o] = head_dat[i];
            end
        end
        pop = gnt[0] | gnt[1] | gnt[2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q <= '0;
            for (int o = 0; o < 3; o++) begin
                rr_q[o]      <= PORT_E;
                out_dat_q[o] <= '0;
            end
        end else begin
            out_vld_q <= out_vld_d;
            for (int o = 0; o < 3; o++) begin
                rr_q[o]      <= rr_d[o];
                out_dat_q[o] <= out_dat_d[o];
            end
        end
    end

    assign dataOutE     = out_dat_q[0];
    assign dataOutW     = out_dat_q[1];
    assign dataOutL     = out_dat_q[2];
    assign writeOutE    = out_vld_q[0];
    assign writeOutW    = out_vld_q[1];
    assign writeOutL    = out_vld_q[2];
    assign fullE        = full[0];
    assign fullW        = full[1];
    assign fullL        = full[2];
    assign almost_fullE = afull[0];
    assign almost_fullW = afull[1];
    assign almost_fullL = afull[2];
endmodule

// File: tb/tb_noc_router.sv
// Two routers (ID 0 and ID 1) share one stimulus stream; a queue-based model predicts every output each cycle.
module tb_noc_router;
    localparam int W = 16;
    localparam int D = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr     [3];
    logic [W-1:0] din    [3];
    logic         dfull  [3];
    logic         dafull [3];
    logic [W-1:0] dout   [2][3];
    logic         wout   [2][3];
    logic         fl     [2][3];
    logic         af     [2][3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    noc_router #(.WIDTH(W), .DEPTH(D), .ID(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .writeE(wr[0]), .writeW(wr[1]), .writeL(wr[2]),
        .read_FullE(dfull[0]), .read_FullW(dfull[1]), .read_FullL(dfull[2]),
        .read_almostFullE(dafull[0]), .read_almostFullW(dafull[1]), .read_almostFullL(dafull[2]),
        .dataInE(din[0]), .dataInW(din[1]), .dataInL(din[2]),
        .dataOutE(dout[0][0]), .dataOutW(dout[0][1]), .dataOutL(dout[0][2]),
        .writeOutE(wout[0][0]), .writeOutW(wout[0][1]), .writeOutL(wout[0][2]),
        .fullE(fl[0][0]), .fullW(fl[0][1]), .fullL(fl[0][2]),
        .almost_fullE(af[0][0]), .almost_fullW(af[0][1]), .almost_fullL(af[0][2])
    );

    noc_router #(.WIDTH(W), .DEPTH(D), .ID(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .writeE(wr[0]), .writeW(wr[1]), .writeL(wr[2]),
        .read_FullE(dfull[0]), .read_FullW(dfull[1]), .read_FullL(dfull[2]),
        .read_almostFullE(dafull[0]), .read_almostFullW(dafull[1]), .read_almostFullL(dafull[2]),
        .dataInE(din[0]), .dataInW(din[1]), .dataInL(din[2]),
        .dataOutE(dout[1][0]), .dataOutW(dout[1][1]), .dataOutL(dout[1][2]),
        .writeOutE(wout[1][0]), .writeOutW(wout[1][1]), .writeOutL(wout[1][2]),
        .fullE(fl[1][0]), .fullW(fl[1][1]), .fullL(fl[1][2]),
        .almost_fullE(af[1][0]), .almost_fullW(af[1][1]), .almost_fullL(af[1][2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Port index: 0=E, 1=W, 2=L for inputs and outputs alike.
    function automatic int route(input logic [W-1:0] f, input int id);
        int d;
        d = (int'(f[W-1:W-2]) - id + 4) % 4;
        if (d == 0) return 2;
        if (d == 3) return 1;
        return 0;
    endfunction

    // Model state, index n*3+port for router n (router n has ID n).
    logic [W-1:0] mq [6][$];
    int           rr [6];
    logic [W-1:0] ed [6];
    logic         ew [6];
    logic         started = 1'b0;

    always @(posedge clk) begin : model
        int   sz [6];
        logic pm [6];
        int   i;
        if (reset) begin
            for (int k = 0; k < 6; k++) begin
                mq[k].delete();
                rr[k] = 0;
                ed[k] = '0;
                ew[k] = 1'b0;
            end
            started = 1'b1;
        end else begin
            for (int k = 0; k < 6; k++) begin
                sz[k] = mq[k].size();
                pm[k] = 1'b0;
            end
            for (int n = 0; n < 2; n++) begin
                for (int o = 0; o < 3; o++) begin
                    ew[n*3+o] = 1'b0;
                    if (!dafull[o] && !dfull[o]) begin
                        for (int s = 0; s < 3; s++) begin
                            i = (rr[n*3+o] + s) % 3;
                            if (!ew[n*3+o] && sz[n*3+i] > 0 && route(mq[n*3+i][0], n) == o) begin
                                ew[n*3+o] = 1'b1;
                                ed[n*3+o] = mq[n*3+i][0];
                                pm[n*3+i] = 1'b1;
                                rr[n*3+o] = (i + 1) % 3;
                            end
                        end
                    end
                end
            end
            for (int k = 0; k < 6; k++) begin
                if (pm[k]) void'(mq[k].pop_front());
                if (wr[k%3] && sz[k] < D) mq[k].push_back(din[k%3]);
            end
        end
    end

    always @(negedge clk) begin : compare
        if (started) begin
            for (int n = 0; n < 2; n++) begin
                for (int o = 0; o < 3; o++) begin
                    chk($sformatf("r%0d p%0d writeOut", n, o), 32'(wout[n][o]), 32'(ew[n*3+o]));
                    chk($sformatf("r%0d p%0d dataOut", n, o), 32'(dout[n][o]), 32'(ed[n*3+o]));
                    chk($sformatf("r%0d p%0d full", n, o), 32'(fl[n][o]), 32'(mq[n*3+o].size() == D));
                    chk($sformatf("r%0d p%0d almost_full", n, o), 32'(af[n][o]),
                        32'(mq[n*3+o].size() >= D - 1));
                end
            end
        end
    end

    task automatic chk_all_idle(input string tag);
        for (int n = 0; n < 2; n++) begin
            for (int o = 0; o < 3; o++) begin
                chk($sformatf("%s r%0d p%0d dataOut", tag, n, o), 32'(dout[n][o]), 32'h0);
                chk($sformatf("%s r%0d p%0d writeOut", tag, n, o), 32'(wout[n][o]), 32'h0);
                chk($sformatf("%s r%0d p%0d full", tag, n, o), 32'(fl[n][o]), 32'h0);
                chk($sformatf("%s r%0d p%0d almost_full", tag, n, o), 32'(af[n][o]), 32'h0);
            end
        end
    endtask

    int           t_port [3] = '{1, 2, 0};
    logic [W-1:0] t_flit [3] = '{16'h8011, 16'h0022, 16'hC033};
    int           t_out  [3] = '{0, 1, 0};

    initial begin
        reset = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wr[p] = 1'b0; din[p] = '0; dfull[p] = 1'b0; dafull[p] = 1'b0;
        end
        tick(); tick();
        reset = 1'b0;
        chk_all_idle("reset");

        // Local delivery at ID 0; the same flit heads West at ID 1.
        wr[2] = 1'b1; din[2] = 16'h0005;
        tick();
        wr[2] = 1'b0;
        tick();
        chk("id0 L data", 32'(dout[0][2]), 32'h0005);
        chk("id0 L wr", 32'(wout[0][2]), 32'h1);
        chk("id0 E idle", 32'(wout[0][0]), 32'h0);
        chk("id0 W idle", 32'(wout[0][1]), 32'h0);
        chk("id1 W data", 32'(dout[1][1]), 32'h0005);

        // ID 1 routing table, one flit at a time.
        for (int c = 0; c < 3; c++) begin
            wr[t_port[c]] = 1'b1; din[t_port[c]] = t_flit[c];
            tick();
            wr[t_port[c]] = 1'b0;
            tick();
            chk($sformatf("id1 route case%0d wr", c), 32'(wout[1][t_out[c]]), 32'h1);
            chk($sformatf("id1 route case%0d data", c), 32'(dout[1][t_out[c]]), 32'(t_flit[c]));
        end

        // Three-way contention for output E at ID 0.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 3; p++) begin
                wr[p] = 1'b1; din[p] = 16'h4001 + 16'(p) + 16'(r * 16);
            end
            tick();
            for (int p = 0; p < 3; p++) wr[p] = 1'b0;
            for (int p = 0; p < 3; p++) begin
                tick();
                chk($sformatf("rr round%0d grant%0d wr", r, p), 32'(wout[0][0]), 32'h1);
                chk($sformatf("rr round%0d grant%0d data", r, p), 32'(dout[0][0]),
                    32'h4001 + 32'(p) + 32'(r * 16));
            end
            tick();
            chk($sformatf("rr round%0d done", r), 32'(wout[0][0]), 32'h0);
        end

        // Backpressure on E while L fills to DEPTH; the extra write is dropped.
        dafull[0] = 1'b1;
        for (int i = 0; i < D; i++) begin
            wr[2] = 1'b1; din[2] = 16'h4100 + 16'(i);
            tick();
            chk("bp E held", 32'(wout[0][0]), 32'h0);
            if (i == D - 3) chk("bp afull at 30", 32'(af[0][2]), 32'h0);
            if (i == D - 2) begin
                chk("bp afull at 31", 32'(af[0][2]), 32'h1);
                chk("bp full at 31", 32'(fl[0][2]), 32'h0);
            end
            if (i == D - 1) chk("bp full at 32", 32'(fl[0][2]), 32'h1);
        end
        din[2] = 16'h4FFF;
        tick();
        chk("bp full after drop", 32'(fl[0][2]), 32'h1);
        wr[2] = 1'b0; dafull[0] = 1'b0;
        tick();
        for (int i = 0; i < D; i++) begin
            chk($sformatf("drain%0d wr", i), 32'(wout[0][0]), 32'h1);
            chk($sformatf("drain%0d data", i), 32'(dout[0][0]), 32'h4100 + 32'(i));
            tick();
        end
        chk("drain end", 32'(wout[0][0]), 32'h0);
        chk("drain empty full", 32'(fl[0][2]), 32'h0);

        // Steady push+pop at count 16, long enough to wrap the pointers.
        dafull[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr[2] = 1'b1; din[2] = 16'h4200 + 16'(i);
            tick();
        end
        dafull[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wr[2] = 1'b1; din[2] = 16'h4210 + 16'(i);
            tick();
            chk($sformatf("stream%0d data", i), 32'(dout[0][0]), 32'h4200 + 32'(i));
            chk($sformatf("stream%0d afull", i), 32'(af[0][2]), 32'h0);
        end
        wr[2] = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("stream last", 32'(dout[0][0]), 32'h4273);
        tick();
        chk("stream idle", 32'(wout[0][0]), 32'h0);

        // Reset with 10 buffered flits at ID 0 and one in flight at ID 1.
        dafull[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr[2] = 1'b1; din[2] = 16'h4300 + 16'(i);
            tick();
        end
        reset = 1'b1; din[2] = 16'h43AA;
        tick();
        reset = 1'b0; wr[2] = 1'b0; dafull[0] = 1'b0;
        chk_all_idle("midreset");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("flushed E %0d", i), 32'(wout[0][0]), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
